// File: rtl/edge_seq_pkg.sv
// edge_seq_pkg: shared definitions for the edge sequencing arbiter.
// Holds the FSM state encoding, command bit positions, response field
// offsets and the phase counter width so every file agrees on them.
package edge_seq_pkg;

   // Controller states, in the order an operation walks through them.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RISE  = 3'd2,
      S_FALL  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // Command word: bit CMD_A_BIT pulses dp_a, bit CMD_MA_BIT pulses dp_ma.
   localparam int CMD_W      = 2;
   localparam int CMD_A_BIT  = 0;
   localparam int CMD_MA_BIT = 1;

   // Response word: {fall_mb, fall_b, rise_mb, rise_b}.
   localparam int RSP_W       = 4;
   localparam int RSP_RISE_B  = 0;
   localparam int RSP_RISE_MB = 1;
   localparam int RSP_FALL_B  = 2;
   localparam int RSP_FALL_MB = 3;

   // Phase length counter width; STEP_CYC must fit in it.
   localparam int PH_CNT_W = 4;

   // A command with no pulse bits set is treated as illegal.
   localparam logic [CMD_W-1:0] CMD_NONE = '0;

   function automatic logic cmd_is_empty(input logic [CMD_W-1:0] c);
      return (c == CMD_NONE);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin winner select.
// A lone request always wins; when both request, the one that was not
// granted last time wins. last=1 means requester 1 was granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   // Pure combinational pick; the caller owns the last-granted pointer.
   always_comb begin
      win = 2'b00;
      if (req == 2'b11) begin
         win = last ? 2'b01 : 2'b10;
      end else begin
         win = req;
      end
   end

endmodule

// File: rtl/edge_seq_arb.sv
// edge_seq_arb: arbitrates two requesters onto a shared edge-responder
// datapath. Each granted operation runs SETUP (lines low), RISE (command
// pulses driven), FALL (lines low) for STEP_CYC cycles each, sampling the
// responder at the end of RISE and FALL, then reports in a one-cycle DONE.
//
// Optional build macro EDGE_SEQ_CNT_EN adds cnt0/cnt1, saturating counts of
// done pulses per requester.
//
// Handshake: a requester raises its req bit and presents its cmd; the block
// latches both in an IDLE cycle, holds gnt one-hot from SETUP through DONE,
// and pulses done (with err/rsp valid) for exactly one cycle. After the latch
// req and cmd are don't-care, so a requester may drop req early and still
// receive its done. At least one IDLE cycle separates two operations.
module edge_seq_arb
   import edge_seq_pkg::*;
#(
   parameter int unsigned STEP_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [CMD_W-1:0] cmd0,
   input  logic [CMD_W-1:0] cmd1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             err,
   output logic [RSP_W-1:0] rsp,
   output logic             dp_a,
   output logic             dp_ma,
   input  logic             dp_b,
   input  logic             dp_mb,
`ifdef EDGE_SEQ_CNT_EN
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
`endif
   output logic [2:0]       dbg_state_o
);

   // Phase counter is loaded with STEP_CYC-1 and the phase ends at zero.
   localparam logic [PH_CNT_W-1:0] PH_RELOAD = PH_CNT_W'(STEP_CYC - 1);

   state_e              state_q, state_d;
   logic [1:0]          win_q, win_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic                last_q, last_d;
   logic [PH_CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]          rise_q, rise_d;
   logic [RSP_W-1:0]    rsp_q, rsp_d;

   logic [1:0]          arb_win;
   logic                ph_last;

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (last_q),
      .win  (arb_win)
   );

   assign ph_last = (cnt_q == '0);

   // State and operation registers; reset aborts any operation silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         win_q   <= 2'b00;
         cmd_q   <= CMD_NONE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         rise_q  <= 2'b00;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cmd_q   <= cmd_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         rsp_q   <= rsp_d;
      end
   end

   // Next-state logic: latch winner in IDLE, time phases, capture responses.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cmd_d   = cmd_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rise_d  = rise_q;
      rsp_d   = rsp_q;

      unique case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               win_d   = arb_win;
               cmd_d   = arb_win[1] ? cmd1 : cmd0;
               last_d  = arb_win[1];
               cnt_d   = PH_RELOAD;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            if (ph_last) begin
               if (cmd_is_empty(cmd_q)) begin
                  // Nothing to pulse: report straight away with a cleared result.
                  rsp_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = PH_RELOAD;
                  state_d = S_RISE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_RISE: begin
            if (ph_last) begin
               rise_d  = {dp_mb, dp_b};
               cnt_d   = PH_RELOAD;
               state_d = S_FALL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_FALL: begin
            if (ph_last) begin
               // The visible result only changes here, entering DONE.
               rsp_d[RSP_RISE_B]  = rise_q[0];
               rsp_d[RSP_RISE_MB] = rise_q[1];
               rsp_d[RSP_FALL_B]  = dp_b;
               rsp_d[RSP_FALL_MB] = dp_mb;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state, so reset clears them at once.
   always_comb begin
      gnt   = 2'b00;
      done  = 2'b00;
      err   = 1'b0;
      dp_a  = 1'b0;
      dp_ma = 1'b0;
      if (state_q != S_IDLE) begin
         gnt = win_q;
      end
      if (state_q == S_RISE) begin
         dp_a  = cmd_q[CMD_A_BIT];
         dp_ma = cmd_q[CMD_MA_BIT];
      end
      if (state_q == S_DONE) begin
         done = win_q;
         err  = cmd_is_empty(cmd_q);
      end
   end

   assign rsp         = rsp_q;
   assign dbg_state_o = state_q;

`ifdef EDGE_SEQ_CNT_EN
   logic [7:0] cnt0_q, cnt1_q;

   // Per-requester completion counters that stick at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else begin
         if (done[0] && (cnt0_q != 8'hFF)) begin
            cnt0_q <= cnt0_q + 8'd1;
         end
         if (done[1] && (cnt1_q != 8'hFF)) begin
            cnt1_q <= cnt1_q + 8'd1;
         end
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_edge_seq_arb.sv
// tb_edge_seq_arb: self-checking bench for edge_seq_arb (STEP_CYC=2).
// Expected results come from an operation-level model: winner by the
// round-robin rule, latency from the phase count, result from the responder
// model (dp_b = dp_a ^ inv_b, dp_mb = dp_ma ^ inv_mb).
module tb_edge_seq_arb;
   import edge_seq_pkg::*;

   localparam int S        = 2;
   localparam int LAT_FULL = 3 * S + 1;
   localparam int LAT_ERR  = S + 1;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req, cmd0, cmd1;
   logic [1:0] gnt, done;
   logic       err;
   logic [3:0] rsp;
   logic       dp_a, dp_ma, dp_b, dp_mb;
   logic [2:0] dbg_state;
   logic       inv_b = 1'b0, inv_mb = 1'b0;
`ifdef EDGE_SEQ_CNT_EN
   logic [7:0] cnt0, cnt1;
`endif

   always #5 clk = ~clk;

   assign dp_b  = dp_a ^ inv_b;
   assign dp_mb = dp_ma ^ inv_mb;

   edge_seq_arb #(.STEP_CYC(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .cmd0        (cmd0),
      .cmd1        (cmd1),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .rsp         (rsp),
      .dp_a        (dp_a),
      .dp_ma       (dp_ma),
      .dp_b        (dp_b),
      .dp_mb       (dp_mb),
`ifdef EDGE_SEQ_CNT_EN
      .cnt0        (cnt0),
      .cnt1        (cnt1),
`endif
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model state ----------------
   int         total = 0;
   int         bad   = 0;
   int         ref_last;
   logic [3:0] ref_rsp;
   logic [6:0] exp_q[$];

   // Winner index: a lone requester wins, a tie goes to whoever was not last.
   function automatic int model_widx(input logic [1:0] r, input int last);
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return 1 - last;
   endfunction

   // Result word {fall_mb, fall_b, rise_mb, rise_b} seen by the responder model.
   function automatic logic [3:0] model_rsp(input logic [1:0] c, input logic ib, input logic imb);
      if (c == 2'b00) return 4'b0000;
      return {imb, ib, c[1] ^ imb, c[0] ^ ib};
   endfunction

   // ---------------- driver tasks ----------------
   // Ends on a negedge in an IDLE cycle with rst released.
   task automatic apply_reset();
      rst  = 1'b1;
      req  = 2'b00;
      cmd0 = 2'b00;
      cmd1 = 2'b00;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      ref_last = 1;
      ref_rsp  = 4'b0000;
   endtask

   // Called at the negedge of the IDLE cycle with req already driven.
   // Watches the operation until done is seen (bounded), optionally changing
   // req / cmds after the latch. lat=0 means done never came.
   task automatic observe_op(input int chg_at, input logic [1:0] chg_req, input bit scramble,
                             output int lat, output logic [1:0] d, output logic e,
                             output logic [3:0] r, output logic [3:0] r_first,
                             output int a_hi, output int ma_hi,
                             output logic [1:0] g_first, output bit g_stable);
      lat = 0; d = 2'b00; e = 1'b0; r = 4'b0000; r_first = 4'b0000;
      a_hi = 0; ma_hi = 0; g_first = 2'b00; g_stable = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            r_first = rsp;
            g_first = gnt;
            if (scramble) begin
               cmd0 = 2'($urandom);
               cmd1 = 2'($urandom);
            end
         end
         if (gnt !== g_first) g_stable = 1'b0;
         if (dp_a === 1'b1) a_hi++;
         if (dp_ma === 1'b1) ma_hi++;
         if (done !== 2'b00) begin
            lat = k; d = done; e = err; r = rsp;
            break;
         end
         if (chg_at != 0 && k == chg_at) req = chg_req;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; req = 2'b00; cmd0 = 2'b00; cmd1 = 2'b00;
      #1;
      total++; if (gnt !== 2'b00)   begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      total++; if (done !== 2'b00)  begin bad++; $display("FAIL reset_done got=%b exp=00", done); end
      total++; if (err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (rsp !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b exp=0000", rsp); end
      total++; if ({dp_ma, dp_a} !== 2'b00) begin bad++; $display("FAIL reset_dp got=%b exp=00", {dp_ma, dp_a}); end
      total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
      repeat (2) @(negedge clk);
      rst = 1'b0; ref_last = 1; ref_rsp = 4'b0000;
      repeat (3) @(negedge clk);
      total++; if (gnt !== 2'b00 || dbg_state !== S_IDLE) begin
         bad++; $display("FAIL idle_noreq gnt=%b state=%0d exp gnt=00 state=0", gnt, dbg_state);
      end
   endtask

   task automatic test_single();
      int lat, a_hi, ma_hi; logic [1:0] d, g; logic e; logic [3:0] r, r0; bit gs;
      logic [3:0] exp_r;
      apply_reset();
      inv_b = 1'b1; inv_mb = 1'b1;
      cmd0 = 2'b01; cmd1 = 2'($urandom); req = 2'b01;
      exp_r = model_rsp(2'b01, 1'b1, 1'b1);
      observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
      ref_last = 0; ref_rsp = exp_r;
      total++; if (lat != LAT_FULL) begin bad++; $display("FAIL single_lat got=%0d exp=%0d", lat, LAT_FULL); end
      total++; if (d !== 2'b01)     begin bad++; $display("FAIL single_done got=%b exp=01", d); end
      total++; if (e !== 1'b0)      begin bad++; $display("FAIL single_err got=%b exp=0", e); end
      total++; if (r[0] !== 1'b0 || r[2] !== 1'b1) begin bad++; $display("FAIL single_rsp_bits got=%b exp rsp[0]=0 rsp[2]=1", r); end
      total++; if (r !== exp_r)     begin bad++; $display("FAIL single_rsp got=%b exp=%b", r, exp_r); end
      total++; if (a_hi != S || ma_hi != 0) begin bad++; $display("FAIL single_dp a_hi=%0d ma_hi=%0d exp %0d/0", a_hi, ma_hi, S); end
      total++; if (g !== 2'b01 || !gs) begin bad++; $display("FAIL single_gnt got=%b stable=%0d exp=01 stable=1", g, gs); end
      req = 2'b00;
      @(negedge clk);
      total++; if (gnt !== 2'b00 || rsp !== exp_r) begin
         bad++; $display("FAIL single_hold gnt=%b rsp=%b exp gnt=00 rsp=%b", gnt, rsp, exp_r);
      end
   endtask

   task automatic test_tie();
      int lat, a_hi, ma_hi, w; logic [1:0] d, g, exp_g; logic e; logic [3:0] r, r0; bit gs;
      apply_reset();
      inv_b = 1'($urandom); inv_mb = 1'($urandom);
      cmd0 = 2'b11; cmd1 = 2'b11; req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         w = model_widx(2'b11, ref_last); ref_last = w;
         exp_g = (w == 0) ? 2'b01 : 2'b10;
         observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
         total++; if (lat != LAT_FULL || d !== exp_g) begin
            bad++; $display("FAIL tie_op%0d lat=%0d done=%b exp lat=%0d done=%b", i, lat, d, LAT_FULL, exp_g);
         end
         total++; if (g !== exp_g || !gs) begin bad++; $display("FAIL tie_gnt%0d got=%b exp=%b", i, g, exp_g); end
         @(negedge clk);
         total++; if (gnt !== 2'b00 || done !== 2'b00) begin
            bad++; $display("FAIL tie_gap%0d gnt=%b done=%b exp 00/00", i, gnt, done);
         end
      end
   endtask

   task automatic test_illegal();
      int lat, a_hi, ma_hi; logic [1:0] d, g; logic e; logic [3:0] r, r0; bit gs;
      apply_reset();
      inv_b = 1'b0; inv_mb = 1'b0;
      req = 2'b10; cmd1 = 2'b11; cmd0 = 2'b00;
      observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
      ref_rsp = model_rsp(2'b11, 1'b0, 1'b0);
      total++; if (r !== ref_rsp) begin bad++; $display("FAIL illegal_pre_rsp got=%b exp=%b", r, ref_rsp); end
      @(negedge clk);
      req = 2'b10; cmd1 = 2'b00; cmd0 = 2'($urandom);
      observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
      total++; if (r0 !== ref_rsp) begin bad++; $display("FAIL illegal_hold got=%b exp=%b", r0, ref_rsp); end
      total++; if (lat != LAT_ERR) begin bad++; $display("FAIL illegal_lat got=%0d exp=%0d", lat, LAT_ERR); end
      total++; if (d !== 2'b10 || e !== 1'b1) begin bad++; $display("FAIL illegal_done done=%b err=%b exp 10/1", d, e); end
      total++; if (r !== 4'b0000) begin bad++; $display("FAIL illegal_rsp got=%b exp=0000", r); end
      total++; if (a_hi != 0 || ma_hi != 0) begin bad++; $display("FAIL illegal_dp a_hi=%0d ma_hi=%0d exp 0/0", a_hi, ma_hi); end
      req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, a_hi, ma_hi; logic [1:0] d, g; logic e; logic [3:0] r, r0; bit gs;
      bit saw_done = 1'b0;
      apply_reset();
      req = 2'b01; cmd0 = 2'b11; cmd1 = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (done !== 2'b00) saw_done = 1'b1;
      end
      rst = 1'b1;
      #1;
      total++; if ({gnt, done, err, rsp, dp_a, dp_ma} !== 11'd0) begin
         bad++; $display("FAIL rstmid_out gnt=%b done=%b err=%b rsp=%b dp=%b%b exp all 0", gnt, done, err, rsp, dp_ma, dp_a);
      end
      total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
      req = 2'b00;
      @(negedge clk);
      rst = 1'b0; ref_last = 1; ref_rsp = 4'b0000;
      repeat (6) begin
         @(negedge clk);
         if (done !== 2'b00) saw_done = 1'b1;
      end
      total++; if (saw_done) begin bad++; $display("FAIL rstmid_nodone got=1 exp=0"); end
      inv_b = 1'b1; inv_mb = 1'b0;
      cmd0 = 2'b01; cmd1 = 2'b10; req = 2'b11;
      observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
      ref_last = model_widx(2'b11, 1);
      total++; if (lat != LAT_FULL || d !== 2'b01) begin
         bad++; $display("FAIL rstmid_next lat=%0d done=%b exp lat=%0d done=01", lat, d, LAT_FULL);
      end
      total++; if (r !== model_rsp(2'b01, 1'b1, 1'b0)) begin
         bad++; $display("FAIL rstmid_rsp got=%b exp=%b", r, model_rsp(2'b01, 1'b1, 1'b0));
      end
      req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_dropped();
      int lat, a_hi, ma_hi; logic [1:0] d, g; logic e; logic [3:0] r, r0; bit gs;
      apply_reset();
      inv_b = 1'b1; inv_mb = 1'b1;
      req = 2'b01; cmd0 = 2'b10; cmd1 = 2'b00;
      observe_op(2, 2'b00, 1'b1, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
      total++; if (lat != LAT_FULL || d !== 2'b01) begin
         bad++; $display("FAIL dropped_done lat=%0d done=%b exp lat=%0d done=01", lat, d, LAT_FULL);
      end
      total++; if (a_hi != 0 || ma_hi != S) begin bad++; $display("FAIL dropped_dp a_hi=%0d ma_hi=%0d exp 0/%0d", a_hi, ma_hi, S); end
      total++; if (r !== model_rsp(2'b10, 1'b1, 1'b1) || e !== 1'b0) begin
         bad++; $display("FAIL dropped_rsp got=%b err=%b exp=%b err=0", r, e, model_rsp(2'b10, 1'b1, 1'b1));
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, a_hi, ma_hi, w, gap, exp_lat; logic [1:0] d, g, r_req, c0, c1, wcmd, exp_g;
      logic e; logic [3:0] r, r0, exp_r; bit gs; logic [6:0] exp_w;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            req = 2'b00;
            repeat (gap) @(negedge clk);
         end
         r_req = 2'($urandom_range(1, 3));
         c0 = 2'($urandom); c1 = 2'($urandom);
         inv_b = 1'($urandom); inv_mb = 1'($urandom);
         req = r_req; cmd0 = c0; cmd1 = c1;
         w = model_widx(r_req, ref_last); ref_last = w;
         wcmd  = (w == 0) ? c0 : c1;
         exp_g = (w == 0) ? 2'b01 : 2'b10;
         exp_r = model_rsp(wcmd, inv_b, inv_mb);
         exp_lat = (wcmd == 2'b00) ? LAT_ERR : LAT_FULL;
         exp_q.push_back({exp_g, (wcmd == 2'b00), exp_r});
         observe_op($urandom_range(0, 3), 2'($urandom), 1'b1, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
         exp_w = exp_q.pop_front();
         total++; if ({d, e, r} !== exp_w) begin
            bad++; $display("FAIL rand%0d_result got=%b exp=%b", i, {d, e, r}, exp_w);
         end
         total++; if (lat != exp_lat) begin bad++; $display("FAIL rand%0d_lat got=%0d exp=%0d", i, lat, exp_lat); end
         total++; if (r0 !== ref_rsp) begin bad++; $display("FAIL rand%0d_hold got=%b exp=%b", i, r0, ref_rsp); end
         total++; if (g !== exp_g || !gs) begin bad++; $display("FAIL rand%0d_gnt got=%b stable=%0d exp=%b", i, g, gs, exp_g); end
         total++; if (a_hi != (wcmd[0] ? S : 0) || ma_hi != (wcmd[1] ? S : 0)) begin
            bad++; $display("FAIL rand%0d_dp a_hi=%0d ma_hi=%0d cmd=%b", i, a_hi, ma_hi, wcmd);
         end
         ref_rsp = exp_r;
         @(negedge clk);
      end
      req = 2'b00;
      @(negedge clk);
   endtask

`ifdef EDGE_SEQ_CNT_EN
   task automatic test_cnt();
      int lat, a_hi, ma_hi, n0; logic [1:0] d, g; logic e; logic [3:0] r, r0; bit gs;
      apply_reset();
      n0 = 0;
      total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL cnt_reset cnt0=%0d cnt1=%0d exp 0/0", cnt0, cnt1); end
      for (int i = 0; i < 300; i++) begin
         req = 2'b01; cmd0 = 2'($urandom); cmd1 = 2'($urandom);
         observe_op(0, 2'b00, 1'b0, lat, d, e, r, r0, a_hi, ma_hi, g, gs);
         if (d === 2'b01) n0 = (n0 + 1 > 255) ? 255 : n0 + 1;
         req = 2'b00;
         @(negedge clk);
         if (i == 9) begin
            total++; if (cnt0 !== 8'(10)) begin bad++; $display("FAIL cnt_partial got=%0d exp=10", cnt0); end
         end
      end
      total++; if (n0 != 255) begin bad++; $display("FAIL cnt_done_seen got=%0d exp=255", n0); end
      total++; if (cnt0 !== 8'd255) begin bad++; $display("FAIL cnt0_sat got=%0d exp=255", cnt0); end
      total++; if (cnt1 !== 8'd0) begin bad++; $display("FAIL cnt1_idle got=%0d exp=0", cnt1); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_tie();
      test_illegal();
      test_reset_mid();
      test_dropped();
      test_random();
`ifdef EDGE_SEQ_CNT_EN
      test_cnt();
`endif
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/edge_seq_arb.md
EDGE_SEQ_ARB -- requirements
Module: edge_seq_arb

Interface
REQ-001 SHALL have parameter STEP_CYC, default 2, cycles each phase is held (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  2  per-requester request, bit n = requester n.
REQ-005 SHALL have port cmd0  input  2  requester 0 command: bit0 pulse dp_a, bit1 pulse dp_ma.
REQ-006 SHALL have port cmd1  input  2  requester 1 command, same encoding.
REQ-007 SHALL have port gnt  output  2  one-hot grant, held SETUP through DONE.
REQ-008 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  1  one-cycle pulse with done when the command was 2'b00.
REQ-010 SHALL have port rsp  output  4  result {fall_mb, fall_b, rise_mb, rise_b}, valid with done.
REQ-011 SHALL have ports dp_a, dp_ma  output  1 each  drive to the shared edge-responder datapath.
REQ-012 SHALL have ports dp_b, dp_mb  input  1 each  datapath responses.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, RISE, FALL, DONE.
REQ-014 IDLE with req!=0 SHALL latch winner and its cmd, go to SETUP next cycle; req==0 stays IDLE.
REQ-015 Arbitration SHALL be round-robin: single request wins; on tie, the requester not granted last wins; requester 0 wins the first tie after reset.
REQ-016 SETUP SHALL drive dp_a=dp_ma=0 for STEP_CYC cycles.
REQ-017 RISE SHALL drive dp_a=cmd[0], dp_ma=cmd[1] for STEP_CYC cycles; {dp_mb,dp_b} sampled on the last RISE cycle into rsp[1:0].
REQ-018 FALL SHALL drive dp_a=dp_ma=0 for STEP_CYC cycles; {dp_mb,dp_b} sampled on the last FALL cycle into rsp[3:2].
REQ-019 DONE SHALL last one cycle, pulse done[winner], then return to IDLE; no back-to-back grant without an IDLE cycle.
REQ-020 Latency: req seen in IDLE at cycle t -> done at t+3*STEP_CYC+1.
REQ-021 Latched cmd==2'b00 SHALL skip RISE/FALL: SETUP -> DONE, err=1, rsp=4'b0000, datapath stays low.
REQ-022 Changes of req or cmd after latch SHALL be ignored; a dropped request still completes.
REQ-023 The phase counter SHALL be 4 bits, reloaded at every phase entry, never wrapping.
REQ-024 rsp SHALL hold its last value until the next DONE.

Reset
REQ-025 rst SHALL force, asynchronously: state IDLE, gnt=0, done=0, err=0, rsp=0, dp_a=dp_ma=0, round-robin pointer to "last=1", counters 0.
REQ-026 rst asserted mid-operation SHALL abort without a done pulse; the first IDLE cycle after release arbitrates fresh.

Configuration
REQ-027 With EDGE_SEQ_CNT_EN defined, the block SHALL add outputs cnt0, cnt1 (8 bits each), each counting done pulses to its requester, saturating at 255, cleared by rst.
REQ-028 Without EDGE_SEQ_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-029 The FSM state encoding, the cmd bit positions and rsp field offsets SHALL live in shared package edge_seq_pkg.
REQ-030 The round-robin winner logic SHALL be sub-module rr_arb2 (inputs req, last; output one-hot win).

Verification
REQ-031 Single request: STEP_CYC=2, req=01, cmd0=01, datapath b=~a -> dp_a high 2 cycles, done=01 at t+7, rsp[0]=0, rsp[2]=1, err=0.
REQ-032 Tie: req=11 held, cmd0=cmd1=11 -> grants in order 01, 10, 01, each done 7 cycles after its IDLE cycle, one IDLE cycle between operations.
REQ-033 Illegal cmd: req=10, cmd1=00 -> done=10 and err=1 at t+3, rsp=0, dp_a/dp_ma never high.
REQ-034 Reset mid-RISE: rst pulse at t+4 -> all outputs 0 immediately, no done, next request arbitrated normally with requester 0 winning a tie.
REQ-035 Counter build: EDGE_SEQ_CNT_EN, 300 completions on requester 0 -> cnt0=255, cnt1=0.
REQ-036 Dropped request: req=01 deasserted at t+2 -> operation still completes, done=01 at t+7.
